bmem_arb: RTL and testbench
===========================

BMEM_ARB -- requirements
Module: bmem_arb

Interface
REQ-001 SHALL have parameter AW, default 10, bitmap memory address width.
REQ-002 SHALL have parameter DW, default 1536, bitmap word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cpu_req  input  1  CPU EXE-stage access request (ldb/stb), level, held until granted.
REQ-006 SHALL have port cpu_we  input  1  1=write (stb), 0=read (ldb).
REQ-007 SHALL have ports cpu_addr  input  AW, and cpu_wdata  input  DW.
REQ-008 SHALL have ports cpu_gnt  output  1, cpu_stall  output  1, cpu_rvalid  output  1, cpu_rdata  output  DW.
REQ-009 SHALL have ports ply_req  input  1, ply_addr  input  AW  (playback engine, read-only requester).
REQ-010 SHALL have ports ply_gnt  output  1, ply_rvalid  output  1, ply_rdata  output  DW.
REQ-011 SHALL have ports mem_addr  output  AW, mem_wren  output  1, mem_data  output  DW, mem_q  input  DW (single-port memory, q registered, 1-cycle read latency).

Function
REQ-012 SHALL grant at most one requester per cycle; cpu_gnt and ply_gnt never both 1.
REQ-013 SHALL compute grants combinationally from cpu_req, ply_req and priority register prio (0=CPU preferred, 1=player preferred).
REQ-014 SHALL grant the sole requester when only one requests, regardless of prio.
REQ-015 SHALL, when both request, grant CPU if prio=0 and player if prio=1.
REQ-016 SHALL set prio to 1 after a CPU grant and 0 after a player grant; prio holds in cycles with no grant.
REQ-017 SHALL drive mem_addr from the granted requester's address; mem_addr=0 when no grant.
REQ-018 SHALL drive mem_wren = cpu_gnt & cpu_we; mem_data = cpu_wdata at all times.
REQ-019 SHALL drive cpu_stall = cpu_req & ~cpu_gnt.
REQ-020 SHALL register a read tag each cycle: rd_cpu <= cpu_gnt & ~cpu_we; rd_ply <= ply_gnt.
REQ-021 SHALL assert cpu_rvalid = rd_cpu and ply_rvalid = rd_ply, exactly one cycle after the granting cycle, for one cycle per read.
REQ-022 SHALL drive cpu_rdata = mem_q and ply_rdata = mem_q; data only meaningful while the matching rvalid is 1.
REQ-023 SHALL produce no rvalid for writes.
REQ-024 SHALL support back-to-back grants every cycle with no bubble; a requester continuously requesting alone is granted every cycle.
REQ-025 SHALL, under continuous dual requests, alternate grants CPU, player, CPU, ... (starting per prio).

Reset
REQ-026 SHALL, while rst=1 at a clock edge, clear prio to 0, rd_cpu and rd_ply to 0, and perf counter (if present) to 0.
REQ-027 SHALL suppress rvalid for a read granted in the cycle rst is sampled; no rvalid in the first cycle after reset.
REQ-028 SHALL keep grant logic combinational during reset but memory writes SHALL be blocked: mem_wren=0 while rst=1.

Configuration
REQ-029 SHALL provide macro BMEM_ARB_PERF_EN; when defined, adds output conflict_cnt (16 bits) counting cycles with cpu_req & ply_req, saturating at 16'hFFFF, cleared by rst.
REQ-030 SHALL, without BMEM_ARB_PERF_EN, omit conflict_cnt port and counter; all other behaviour identical.

Verification
REQ-031 SHALL verify solo CPU read: cpu_req=1, cpu_we=0, cpu_addr=0x005 for one cycle -> cpu_gnt=1, mem_addr=0x005, mem_wren=0 same cycle; cpu_rvalid=1, cpu_rdata=mem_q next cycle; ply_rvalid=0.
REQ-032 SHALL verify CPU write: cpu_req=1, cpu_we=1, cpu_addr=0x3FF -> mem_wren=1, mem_addr=0x3FF, no cpu_rvalid afterwards.
REQ-033 SHALL verify contention after reset: cpu_req=ply_req=1 held 4 cycles -> grants CPU, PLY, CPU, PLY; cpu_stall=0,1,0,1; rvalids follow one cycle later.
REQ-034 SHALL verify player streaming: ply_req=1 for 8 cycles, addresses 0x010..0x017, cpu_req=0 -> ply_gnt=1 all 8 cycles, 8 consecutive ply_rvalid pulses.
REQ-035 SHALL verify reset mid-read: player read granted in cycle N, rst=1 at edge ending N -> ply_rvalid=0 in N+1; prio=0 so next dual request grants CPU.
REQ-036 SHALL verify, with BMEM_ARB_PERF_EN, 5 dual-request cycles -> conflict_cnt=5; counter held at 16'hFFFF when forced to saturation.

Source files
------------

// File: rtl/bmem_arb_if.sv
// Bitmap memory arbiter bus: CPU requester, playback requester and
// single-port memory signals grouped together. The arbiter uses the
// slave view; the requesters/memory side uses the master view.
interface bmem_arb_if #(
    parameter int AW = 10,
    parameter int DW = 1536
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          ply_req;
    logic [AW-1:0] ply_addr;
    logic          ply_gnt;
    logic          ply_rvalid;
    logic [DW-1:0] ply_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_wren;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ply_req, ply_addr,
        input  mem_q,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output ply_gnt, ply_rvalid, ply_rdata,
        output mem_addr, mem_wren, mem_data
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ply_req, ply_addr,
        output mem_q,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  ply_gnt, ply_rvalid, ply_rdata,
        input  mem_addr, mem_wren, mem_data
    );
endinterface

// File: rtl/bmem_arb.sv
// Bitmap memory arbiter: shares one single-port memory (registered q,
// 1-cycle read latency) between the CPU (ldb/stb) and the playback engine.
// Grants are combinational; on contention a one-bit priority register
// alternates the winner so neither side starves.
// Optional macro BMEM_ARB_PERF_EN adds a saturating 16-bit conflict_cnt
// output counting cycles in which both requesters asked at once.
module bmem_arb #(
    parameter int AW = 10,
    parameter int DW = 1536
) (
    input  logic        clk,
    input  logic        rst,
    bmem_arb_if.slave   bus
`ifdef BMEM_ARB_PERF_EN
    ,
    output logic [15:0] conflict_cnt
`endif
);

    typedef enum logic {
        PRIO_CPU = 1'b0,
        PRIO_PLY = 1'b1
    } prio_e;

    prio_e         r_prio;
    logic          r_rdCpu;
    logic          r_rdPly;
    logic          w_cpuGnt;
    logic          w_plyGnt;
    logic [AW-1:0] w_memAddr;
    logic [DW-1:0] w_memQ;

    // Pick the winner: a lone requester always wins, otherwise prio decides.
    always_comb begin
        w_cpuGnt = 1'b0;
        w_plyGnt = 1'b0;
        if (bus.cpu_req && (!bus.ply_req || r_prio == PRIO_CPU)) begin
            w_cpuGnt = 1'b1;
        end else if (bus.ply_req) begin
            w_plyGnt = 1'b1;
        end
    end

    // Route the winner's address to the memory; park at zero when idle.
    always_comb begin
        w_memAddr = '0;
        if (w_cpuGnt) begin
            w_memAddr = bus.cpu_addr;
        end else if (w_plyGnt) begin
            w_memAddr = bus.ply_addr;
        end
    end

    assign w_memQ         = bus.mem_q;

    assign bus.cpu_gnt    = w_cpuGnt;
    assign bus.ply_gnt    = w_plyGnt;
    assign bus.cpu_stall  = bus.cpu_req & ~w_cpuGnt;
    assign bus.mem_addr   = w_memAddr;
    assign bus.mem_wren   = w_cpuGnt & bus.cpu_we & ~rst;
    assign bus.mem_data   = bus.cpu_wdata;

    assign bus.cpu_rvalid = r_rdCpu;
    assign bus.ply_rvalid = r_rdPly;
    assign bus.cpu_rdata  = w_memQ;
    assign bus.ply_rdata  = w_memQ;

    // Hand priority to the other side after each grant; hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= PRIO_CPU;
        end else if (w_cpuGnt) begin
            r_prio <= PRIO_PLY;
        end else if (w_plyGnt) begin
            r_prio <= PRIO_CPU;
        end
    end

    // Tag reads so the returning memory word is flagged to the right owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdCpu <= 1'b0;
            r_rdPly <= 1'b0;
        end else begin
            r_rdCpu <= w_cpuGnt & ~bus.cpu_we;
            r_rdPly <= w_plyGnt;
        end
    end

`ifdef BMEM_ARB_PERF_EN
    logic [15:0] r_conflictCnt;

    // Count contention cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflictCnt <= '0;
        end else if (bus.cpu_req && bus.ply_req && r_conflictCnt != 16'hFFFF) begin
            r_conflictCnt <= r_conflictCnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflictCnt;
`endif

endmodule

// File: tb/tb_bmem_arb.sv
// Self-checking bench for bmem_arb. Holds its own memory model with a
// registered read port, predicts grants/priority independently, and queues
// the expected read-return of every cycle for comparison one cycle later.
// Define BMEM_ARB_PERF_EN to also exercise conflict_cnt.
`timescale 1ns/1ps
module tb_bmem_arb;

    localparam int AW = 10;
    localparam int DW = 64;

    typedef struct {
        logic          cpuV;
        logic          plyV;
        logic [DW-1:0] data;
    } rdExp_t;

    logic clk = 1'b0;
    logic rst;

    int numCompared   = 0;
    int numMismatched = 0;

    rdExp_t        sbQ[$];
    logic [DW-1:0] memArray [0:(1<<AW)-1];
    logic [DW-1:0] shadow   [0:(1<<AW)-1];
    logic          mPrio;
    int unsigned   mConf;

    bmem_arb_if #(.AW(AW), .DW(DW)) bus();

`ifdef BMEM_ARB_PERF_EN
    logic [15:0] conflictCnt;
`endif

    bmem_arb #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef BMEM_ARB_PERF_EN
        ,
        .conflict_cnt (conflictCnt)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single-port memory with registered output.
    always @(posedge clk) begin
        if (bus.mem_wren) memArray[bus.mem_addr] <= bus.mem_data;
        bus.mem_q <= memArray[bus.mem_addr];
    end

    // Give up if the run ever stops making progress.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] initPattern(input logic [AW-1:0] a);
        return {32'hB17E_0000, 22'h0, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        numCompared++;
        if (obs !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational and returning outputs, update model.
    task automatic applyStimulus(input logic cReq, input logic cWe, input logic [AW-1:0] cAddr,
                                 input logic [DW-1:0] cWdata, input logic pReq,
                                 input logic [AW-1:0] pAddr, input logic rstVal);
        logic          eCpu, ePly;
        logic [AW-1:0] eAddr;
        rdExp_t        e;
        @(posedge clk);
        #1;
        rst           = rstVal;
        bus.cpu_req   = cReq;
        bus.cpu_we    = cWe;
        bus.cpu_addr  = cAddr;
        bus.cpu_wdata = cWdata;
        bus.ply_req   = pReq;
        bus.ply_addr  = pAddr;
        @(negedge clk);
        eCpu  = cReq && (!pReq || !mPrio);
        ePly  = pReq && !eCpu;
        eAddr = eCpu ? cAddr : (ePly ? pAddr : '0);
        checkOutput("cpu_gnt",   bus.cpu_gnt,   eCpu);
        checkOutput("ply_gnt",   bus.ply_gnt,   ePly);
        checkOutput("cpu_stall", bus.cpu_stall, cReq && !eCpu);
        checkOutput("mem_addr",  bus.mem_addr,  eAddr);
        checkOutput("mem_wren",  bus.mem_wren,  eCpu && cWe && !rstVal);
        checkOutput("mem_data",  bus.mem_data,  cWdata);
`ifdef BMEM_ARB_PERF_EN
        checkOutput("conflict_cnt", conflictCnt, mConf);
`endif
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("cpu_rvalid", bus.cpu_rvalid, e.cpuV);
            checkOutput("ply_rvalid", bus.ply_rvalid, e.plyV);
            if (e.cpuV) checkOutput("cpu_rdata", bus.cpu_rdata, e.data);
            if (e.plyV) checkOutput("ply_rdata", bus.ply_rdata, e.data);
        end
        e.cpuV = eCpu && !cWe && !rstVal;
        e.plyV = ePly && !rstVal;
        e.data = shadow[eAddr];
        sbQ.push_back(e);
        if (eCpu && cWe && !rstVal) shadow[cAddr] = cWdata;
        if (rstVal) begin
            mPrio = 1'b0;
            mConf = 0;
        end else begin
            if (eCpu)      mPrio = 1'b1;
            else if (ePly) mPrio = 1'b0;
            if (cReq && pReq && mConf != 32'hFFFF) mConf++;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.ply_req   = 1'b0;
        bus.ply_addr  = '0;
        mPrio         = 1'b0;
        mConf         = 0;
        for (int i = 0; i < (1<<AW); i++) begin
            memArray[i] = initPattern(AW'(i));
            shadow[i]   = initPattern(AW'(i));
        end

        // Reset; a write requested during reset is granted but must not reach memory.
        applyStimulus(0, 0, '0,      '0,                     0, '0, 1);
        applyStimulus(1, 1, 10'h100, 64'hDEAD_BEEF_0000_0100, 0, '0, 1);
        applyStimulus(0, 0, '0,      '0,                     0, '0, 0);

        // Solo CPU read.
        applyStimulus(1, 0, 10'h005, '0, 0, '0, 0);
        applyStimulus(0, 0, '0,      '0, 0, '0, 0);

        // CPU write at top address, then read it back.
        applyStimulus(1, 1, 10'h3FF, 64'h0123_4567_89AB_CDEF, 0, '0, 0);
        applyStimulus(0, 0, '0,      '0, 0, '0, 0);
        applyStimulus(1, 0, 10'h3FF, '0, 0, '0, 0);
        applyStimulus(0, 0, '0,      '0, 0, '0, 0);

        // Contention right after reset: CPU, PLY, CPU, PLY.
        applyStimulus(0, 0, '0, '0, 0, '0, 1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, 10'h020, '0, 1, 10'h021, 0);
        applyStimulus(0, 0, '0, '0, 0, '0, 0);

        // Player streaming alone.
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 0, '0, '0, 1, AW'(10'h010 + i), 0);
        applyStimulus(0, 0, '0, '0, 0, '0, 0);

        // Reset while reads are in flight; priority returns to the CPU.
        applyStimulus(1, 0, 10'h006, '0, 0, '0,      0);
        applyStimulus(0, 0, '0,      '0, 1, 10'h030, 1);
        applyStimulus(1, 0, 10'h007, '0, 0, '0,      1);
        applyStimulus(1, 0, 10'h008, '0, 1, 10'h009, 0);
        applyStimulus(0, 0, '0,      '0, 0, '0,      0);

        // Address written only during reset must still hold its original word.
        applyStimulus(0, 0, '0, '0, 1, 10'h100, 0);

        // Random mix; writes confined to one region so read data stays traceable.
        for (int i = 0; i < 40; i++) begin
            logic          cReq, cWe, pReq;
            logic [AW-1:0] cAddr, pAddr;
            cReq  = 1'($urandom_range(0, 1));
            cWe   = 1'($urandom_range(0, 1));
            pReq  = 1'($urandom_range(0, 1));
            cAddr = cWe ? AW'(10'h200 + $urandom_range(0, 255)) : AW'($urandom_range(0, 1023));
            pAddr = AW'($urandom_range(0, 1023));
            applyStimulus(cReq, cWe, cAddr, {$urandom, $urandom}, pReq, pAddr, 0);
        end
        applyStimulus(0, 0, '0, '0, 0, '0, 0);

`ifdef BMEM_ARB_PERF_EN
        // Five contention cycles, then let the counter saturate.
        applyStimulus(0, 0, '0, '0, 0, '0, 1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 0, 10'h040, '0, 1, 10'h041, 0);
        applyStimulus(0, 0, '0, '0, 0, '0, 0);
        checkOutput("conflict_five", conflictCnt, 64'd5);
        sbQ.delete();
        bus.cpu_req = 1'b1;
        bus.ply_req = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            mPrio = ~mPrio;
            if (mConf != 32'hFFFF) mConf++;
        end
        #1;
        bus.cpu_req = 1'b0;
        bus.ply_req = 1'b0;
        applyStimulus(0, 0, '0, '0, 0, '0, 0);
        checkOutput("conflict_sat", conflictCnt, 64'hFFFF);
        applyStimulus(0, 0, '0, '0, 0, '0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
